sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce_pkg.sv | 21 ++
 rtl/sw_debounce_bit.sv | 110 +++++++++++
 rtl/sw_debounce.sv | 46 ++++
 tb/tb_sw_debounce.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared switch-conditioning constants and the per-bit debounce state encoding.
// Imported by the debounce top level and its per-bit engine.
package sw_debounce_pkg;

    localparam int SWITCH_WIDTH            = 10;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;  // 1 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_MAX     = 1 << 20;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } db_state_t;

    // The accepted level is high while stable high or while a fall is still being qualified.
    function automatic logic level_of(db_state_t s);
        return (s == STABLE_HI) || (s == WAIT_LO);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch channel: two-flop synchroniser, four-state debounce FSM with a
// saturating qualification counter, registered level and edge pulses.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERMINAL = CW'(DEBOUNCE_CYCLES - 2);

    generate
        if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > DEBOUNCE_CYCLES_MAX) begin : g_bad_cycles
            $error("sw_debounce_bit: DEBOUNCE_CYCLES must be in 2..2^20");
        end
    endgenerate

    logic          sync_meta_reg;
    logic          sync_reg;
    db_state_t     state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic          level_reg, level_next;
    logic          rise_reg;
    logic          fall_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta_reg <= 1'b0;
            sync_reg      <= 1'b0;
        end else begin
            sync_meta_reg <= raw;
            sync_reg      <= sync_meta_reg;
        end
    end

    // Entering WAIT takes one edge and leaving it takes DEBOUNCE_CYCLES-1 more,
    // so the terminal count is DEBOUNCE_CYCLES-2 and the counter never wraps.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            STABLE_LO: begin
                if (sync_reg) begin
                    state_next = WAIT_HI;
                    count_next = '0;
                end
            end
            WAIT_HI: begin
                if (!sync_reg) begin
                    state_next = STABLE_LO;
                    count_next = '0;
                end else if (count_reg == TERMINAL) begin
                    state_next = STABLE_HI;
                end else begin
                    count_next = count_reg + CW'(1);
                end
            end
            STABLE_HI: begin
                if (!sync_reg) begin
                    state_next = WAIT_LO;
                    count_next = '0;
                end
            end
            WAIT_LO: begin
                if (sync_reg) begin
                    state_next = STABLE_HI;
                    count_next = '0;
                end else if (count_reg == TERMINAL) begin
                    state_next = STABLE_LO;
                end else begin
                    count_next = count_reg + CW'(1);
                end
            end
            default: begin
                state_next = STABLE_LO;
                count_next = '0;
            end
        endcase
    end

    assign level_next = level_of(state_next);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= STABLE_LO;
            count_reg <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            level_reg <= level_next;
            rise_reg  <= level_next & ~level_reg;
            fall_reg  <= ~level_next & level_reg;
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/sw_debounce.sv
// Debounces N_SW board switches; the top bit is the core's active-low run
// control, so it reads 0 until its debounced 1 has propagated after reset.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int N_SW            = SWITCH_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_out,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic            any_change
);

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
            $error("sw_debounce: DEBOUNCE_CYCLES must be at least 2");
        end
        if (N_SW < 1) begin : g_bad_width
            $error("sw_debounce: N_SW must be at least 1");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < N_SW; gi++) begin : g_bit
            sw_debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_bit (
                .clk  (clk),
                .reset(reset),
                .raw  (sw_raw[gi]),
                .level(sw_out[gi]),
                .rise (sw_rise[gi]),
                .fall (sw_fall[gi])
            );
        end
    endgenerate

    // Edge pulses are already registered per bit; the summary flag is a plain OR.
    assign any_change = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce (N_SW=4, DEBOUNCE_CYCLES=4): expected edge events are
// queued at stimulus time and matched against events captured from the outputs.
module tb_sw_debounce;

    localparam int N  = 4;
    localparam int DC = 4;

    typedef struct packed {
        logic [31:0]  cyc;
        logic [N-1:0] out;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic         any;
    } ev_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] sw_raw = '0;
    logic [N-1:0] sw_out, sw_rise, sw_fall;
    logic         any_change;

    int   cyc = 0;
    int   cmp_cnt = 0;
    int   err_cnt = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    sw_debounce #(.N_SW(N), .DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_raw    (sw_raw),
        .sw_out    (sw_out),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .any_change(any_change)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every cycle that shows any edge activity.
    always @(negedge clk) begin
        if ((sw_rise | sw_fall) != '0 || any_change)
            obs_q.push_back('{cyc: cyc, out: sw_out, rise: sw_rise, fall: sw_fall, any: any_change});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ev_t o;
        repeat (3) step();
        @(negedge clk);
        cmp_cnt++;
        if ({sw_out, sw_rise, sw_fall, any_change} !== '0) begin
            err_cnt++;
            $display("FAIL reset_state: got out=%b rise=%b fall=%b any=%b, want all 0",
                     sw_out, sw_rise, sw_fall, any_change);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cmp_cnt++;
            if (sw_out !== 4'b0000) begin
                err_cnt++;
                $display("FAIL idle_low: cyc=%0d got sw_out=%b, want 0000", cyc, sw_out);
            end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            cmp_cnt++; err_cnt++;
            $display("FAIL idle_pulse: unexpected event cyc=%0d rise=%b fall=%b any=%b",
                     o.cyc, o.rise, o.fall, o.any);
        end
        $display("test_reset done");
    endtask

    task automatic test_rise();
        ev_t e, o;
        int  k;
        step();
        k = cyc;
        sw_raw[0] = 1'b1;
        exp_q.push_back('{cyc: k + 6, out: 4'b0001, rise: 4'b0001, fall: 4'b0000, any: 1'b1});
        do @(negedge clk); while (cyc != k + 5);
        cmp_cnt++;
        if (sw_out !== 4'b0000) begin
            err_cnt++;
            $display("FAIL rise_early: cyc=%0d got sw_out=%b, want 0000", cyc, sw_out);
        end
        @(negedge clk);
        cmp_cnt++;
        if (sw_out !== 4'b0001) begin
            err_cnt++;
            $display("FAIL rise_latency: cyc=%0d got sw_out=%b, want 0001", cyc, sw_out);
        end
        repeat (4) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp_cnt++;
            if (obs_q.size() == 0) begin
                err_cnt++;
                $display("FAIL rise_event: missing, want cyc=%0d rise=%b", e.cyc, e.rise);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    err_cnt++;
                    $display("FAIL rise_event: got cyc=%0d out=%b rise=%b fall=%b any=%b, want cyc=%0d out=%b rise=%b fall=%b any=%b",
                             o.cyc, o.out, o.rise, o.fall, o.any, e.cyc, e.out, e.rise, e.fall, e.any);
                end
            end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            cmp_cnt++; err_cnt++;
            $display("FAIL rise_extra: unexpected event cyc=%0d rise=%b fall=%b", o.cyc, o.rise, o.fall);
        end
        $display("test_rise done");
    endtask

    task automatic test_glitch();
        ev_t o;
        step();
        sw_raw[1] = 1'b1;
        repeat (3) step();
        sw_raw[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cmp_cnt++;
            if (sw_out !== 4'b0001) begin
                err_cnt++;
                $display("FAIL glitch_level: cyc=%0d got sw_out=%b, want 0001", cyc, sw_out);
            end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            cmp_cnt++; err_cnt++;
            $display("FAIL glitch_pulse: unexpected event cyc=%0d rise=%b fall=%b", o.cyc, o.rise, o.fall);
        end
        $display("test_glitch done");
    endtask

    task automatic test_bounce();
        ev_t        e, o;
        int         k, k2;
        logic [5:0] pat;
        pat = 6'b111101;
        step();
        k = cyc;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            sw_raw[1] = pat[i];
        end
        // Last low sample is driven at k+1, so the effective step starts at k+2.
        exp_q.push_back('{cyc: k + 8, out: 4'b0011, rise: 4'b0010, fall: 4'b0000, any: 1'b1});
        do @(negedge clk); while (cyc != k + 7);
        cmp_cnt++;
        if (sw_out !== 4'b0001) begin
            err_cnt++;
            $display("FAIL bounce_early: cyc=%0d got sw_out=%b, want 0001", cyc, sw_out);
        end
        @(negedge clk);
        cmp_cnt++;
        if (sw_out !== 4'b0011) begin
            err_cnt++;
            $display("FAIL bounce_settle: cyc=%0d got sw_out=%b, want 0011", cyc, sw_out);
        end
        step();
        k2 = cyc;
        sw_raw = 4'b0000;
        exp_q.push_back('{cyc: k2 + 6, out: 4'b0000, rise: 4'b0000, fall: 4'b0011, any: 1'b1});
        do @(negedge clk); while (cyc != k2 + 10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp_cnt++;
            if (obs_q.size() == 0) begin
                err_cnt++;
                $display("FAIL bounce_event: missing, want cyc=%0d rise=%b fall=%b", e.cyc, e.rise, e.fall);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    err_cnt++;
                    $display("FAIL bounce_event: got cyc=%0d out=%b rise=%b fall=%b any=%b, want cyc=%0d out=%b rise=%b fall=%b any=%b",
                             o.cyc, o.out, o.rise, o.fall, o.any, e.cyc, e.out, e.rise, e.fall, e.any);
                end
            end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            cmp_cnt++; err_cnt++;
            $display("FAIL bounce_extra: unexpected event cyc=%0d rise=%b fall=%b", o.cyc, o.rise, o.fall);
        end
        $display("test_bounce done");
    endtask

    task automatic test_back_to_back();
        ev_t e, o;
        int  k;
        step();
        k = cyc;
        sw_raw = 4'b1111;
        exp_q.push_back('{cyc: k + 6, out: 4'b1111, rise: 4'b1111, fall: 4'b0000, any: 1'b1});
        do @(negedge clk); while (cyc != k + 6);
        cmp_cnt++;
        if (sw_out !== 4'b1111) begin
            err_cnt++;
            $display("FAIL simul_level: cyc=%0d got sw_out=%b, want 1111", cyc, sw_out);
        end
        repeat (4) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp_cnt++;
            if (obs_q.size() == 0) begin
                err_cnt++;
                $display("FAIL simul_event: missing, want cyc=%0d rise=%b", e.cyc, e.rise);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    err_cnt++;
                    $display("FAIL simul_event: got cyc=%0d out=%b rise=%b fall=%b any=%b, want cyc=%0d out=%b rise=%b fall=%b any=%b",
                             o.cyc, o.out, o.rise, o.fall, o.any, e.cyc, e.out, e.rise, e.fall, e.any);
                end
            end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            cmp_cnt++; err_cnt++;
            $display("FAIL simul_extra: unexpected event cyc=%0d rise=%b fall=%b any=%b", o.cyc, o.rise, o.fall, o.any);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid_wait();
        ev_t e, o;
        int  k, r;
        step();
        k = cyc;
        sw_raw = 4'b1011;
        // Bit 2 enters WAIT_LO at edge k+3; reset lands after edge k+4.
        do @(negedge clk); while (cyc != k + 3);
        cmp_cnt++;
        if (sw_out !== 4'b1111) begin
            err_cnt++;
            $display("FAIL wait_lo_level: cyc=%0d got sw_out=%b, want 1111", cyc, sw_out);
        end
        step();
        reset = 1'b1;
        #1;
        cmp_cnt++;
        if ({sw_out, sw_rise, sw_fall, any_change} !== '0) begin
            err_cnt++;
            $display("FAIL async_reset: got out=%b rise=%b fall=%b any=%b, want all 0",
                     sw_out, sw_rise, sw_fall, any_change);
        end
        sw_raw = 4'b0100;
        repeat (2) step();
        r = cyc;
        reset = 1'b0;
        exp_q.push_back('{cyc: r + 6, out: 4'b0100, rise: 4'b0100, fall: 4'b0000, any: 1'b1});
        do @(negedge clk); while (cyc != r + 5);
        cmp_cnt++;
        if (sw_out !== 4'b0000) begin
            err_cnt++;
            $display("FAIL post_reset_early: cyc=%0d got sw_out=%b, want 0000", cyc, sw_out);
        end
        @(negedge clk);
        cmp_cnt++;
        if (sw_out !== 4'b0100) begin
            err_cnt++;
            $display("FAIL post_reset_level: cyc=%0d got sw_out=%b, want 0100", cyc, sw_out);
        end
        repeat (4) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp_cnt++;
            if (obs_q.size() == 0) begin
                err_cnt++;
                $display("FAIL post_reset_event: missing, want cyc=%0d rise=%b", e.cyc, e.rise);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    err_cnt++;
                    $display("FAIL post_reset_event: got cyc=%0d out=%b rise=%b fall=%b any=%b, want cyc=%0d out=%b rise=%b fall=%b any=%b",
                             o.cyc, o.out, o.rise, o.fall, o.any, e.cyc, e.out, e.rise, e.fall, e.any);
                end
            end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            cmp_cnt++; err_cnt++;
            $display("FAIL post_reset_extra: unexpected event cyc=%0d rise=%b fall=%b", o.cyc, o.rise, o.fall);
        end
        $display("test_reset_mid_wait done");
    endtask

    initial begin
        test_reset();
        test_rise();
        test_glitch();
        test_bounce();
        test_back_to_back();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
